axi_tlb_lookup_arb: RTL and testbench



---
 rtl/axi_tlb_lookup_arb.sv | 135 +++++++++++++
 tb/tb_axi_tlb_lookup_arb.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_tlb_lookup_arb.sv
// Shares one translation lookup engine between the AW (write) and AR (read) requesters.
// Round-robin arbitration with a handshake lock; an in-order tag FIFO routes results back.
module axi_tlb_lookup_arb #(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned MaxOutstanding = 2,
    parameter type         res_t          = logic,
    parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [AddrWidth-1:0] wr_req_addr_i,
    input  logic                 wr_req_valid_i,
    output logic                 wr_req_ready_o,
    output res_t                 wr_res_o,
    output logic                 wr_res_valid_o,
    input  logic                 wr_res_ready_i,
    input  logic [AddrWidth-1:0] rd_req_addr_i,
    input  logic                 rd_req_valid_i,
    output logic                 rd_req_ready_o,
    output res_t                 rd_res_o,
    output logic                 rd_res_valid_o,
    input  logic                 rd_res_ready_i,
    output logic [AddrWidth-1:0] lkp_req_addr_o,
    output logic                 lkp_req_valid_o,
    input  logic                 lkp_req_ready_i,
    input  res_t                 lkp_res_i,
    input  logic                 lkp_res_valid_i,
    output logic                 lkp_res_ready_o,
    output logic [CntWidth-1:0]  outstanding_o
);

    localparam int unsigned         PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [CntWidth-1:0] MaxCnt   = CntWidth'(MaxOutstanding);
    localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(MaxOutstanding - 1);

    logic [CntWidth-1:0] count_reg, count_next;
    logic [PtrWidth-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PtrWidth-1:0] rd_ptr_reg, rd_ptr_next;
    logic                tag_mem [MaxOutstanding];
    logic                rr_rd_reg, rr_rd_next;
    logic                lock_valid_reg, lock_valid_next;
    logic                lock_rd_reg, lock_rd_next;
    logic                full, empty, grant_rd, req_hs, res_hs, head_rd;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrWidth'(1);
    endfunction

    assign full  = (count_reg == MaxCnt);
    assign empty = (count_reg == '0);

    // A stalled request keeps its grant so the engine sees a stable address.
    always_comb begin
        grant_rd = 1'b0;
        if (lock_valid_reg) begin
            grant_rd = lock_rd_reg;
        end else if (wr_req_valid_i && rd_req_valid_i) begin
            grant_rd = rr_rd_reg;
        end else begin
            grant_rd = rd_req_valid_i;
        end
    end

    assign lkp_req_valid_o = !full && (wr_req_valid_i || rd_req_valid_i);
    assign lkp_req_addr_o  = grant_rd ? rd_req_addr_i : wr_req_addr_i;
    assign wr_req_ready_o  = wr_req_valid_i && !grant_rd && lkp_req_ready_i && !full;
    assign rd_req_ready_o  = rd_req_valid_i &&  grant_rd && lkp_req_ready_i && !full;
    assign req_hs          = lkp_req_valid_o && lkp_req_ready_i;

    // Results return in order; only the requester at the FIFO head sees valid.
    assign head_rd         = tag_mem[rd_ptr_reg];
    assign wr_res_o        = lkp_res_i;
    assign rd_res_o        = lkp_res_i;
    assign wr_res_valid_o  = lkp_res_valid_i && !empty && !head_rd;
    assign rd_res_valid_o  = lkp_res_valid_i && !empty &&  head_rd;
    assign lkp_res_ready_o = !empty && (head_rd ? rd_res_ready_i : wr_res_ready_i);
    assign res_hs          = lkp_res_valid_i && lkp_res_ready_o;
    assign outstanding_o   = count_reg;

    always_comb begin
        count_next = count_reg;
        if (req_hs && !res_hs) begin
            count_next = count_reg + CntWidth'(1);
        end else if (!req_hs && res_hs) begin
            count_next = count_reg - CntWidth'(1);
        end
        wr_ptr_next     = req_hs ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
        rd_ptr_next     = res_hs ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
        rr_rd_next      = req_hs ? !grant_rd : rr_rd_reg;
        lock_valid_next = lkp_req_valid_o && !lkp_req_ready_i;
        lock_rd_next    = lock_valid_next ? grant_rd : lock_rd_reg;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_reg      <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            rr_rd_reg      <= 1'b0;
            lock_valid_reg <= 1'b0;
            lock_rd_reg    <= 1'b0;
        end else begin
            count_reg      <= count_next;
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            rr_rd_reg      <= rr_rd_next;
            lock_valid_reg <= lock_valid_next;
            lock_rd_reg    <= lock_rd_next;
        end
    end

    // Tag storage needs no reset: entries are only read once written.
    for (genvar gi = 0; gi < MaxOutstanding; gi++) begin : g_tag
        always_ff @(posedge clk_i) begin
            if (req_hs && (wr_ptr_reg == PtrWidth'(gi))) begin
                tag_mem[gi] <= grant_rd;
            end
        end
    end

    a_max_outstanding: assert property (@(posedge clk_i) MaxOutstanding >= 1);
    a_wr_req_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        wr_req_valid_i && !wr_req_ready_o |=> wr_req_valid_i && $stable(wr_req_addr_i));
    a_rd_req_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        rd_req_valid_i && !rd_req_ready_o |=> rd_req_valid_i && $stable(rd_req_addr_i));
    a_lkp_req_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lkp_req_valid_o && !lkp_req_ready_i |=> lkp_req_valid_o && $stable(lkp_req_addr_o));
    a_lkp_res_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lkp_res_valid_i && !lkp_res_ready_o |=> lkp_res_valid_i && $stable(lkp_res_i));
    a_res_not_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        lkp_res_valid_i |-> !empty);
    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_reg <= MaxCnt);

endmodule

// File: tb/tb_axi_tlb_lookup_arb.sv
// Bench for axi_tlb_lookup_arb: directed scenarios with an in-order result scoreboard.
module tb_axi_tlb_lookup_arb;

    typedef struct packed {
        logic        rd;
        logic [15:0] data;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] wr_req_addr_i, rd_req_addr_i, lkp_req_addr_o;
    logic        wr_req_valid_i, wr_req_ready_o, wr_res_valid_o, wr_res_ready_i;
    logic        rd_req_valid_i, rd_req_ready_o, rd_res_valid_o, rd_res_ready_i;
    logic [15:0] wr_res_o, rd_res_o, lkp_res_i;
    logic        lkp_req_valid_o, lkp_req_ready_i, lkp_res_valid_i, lkp_res_ready_o;
    logic [1:0]  outstanding_o;

    int   tests_run    = 0;
    int   tests_failed = 0;
    exp_t exp_q[$];
    exp_t e;
    bit   ok;

    always #5 clk_i = ~clk_i;

    axi_tlb_lookup_arb #(
        .AddrWidth(32),
        .MaxOutstanding(2),
        .res_t(logic [15:0])
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .wr_req_addr_i(wr_req_addr_i), .wr_req_valid_i(wr_req_valid_i), .wr_req_ready_o(wr_req_ready_o),
        .wr_res_o(wr_res_o), .wr_res_valid_o(wr_res_valid_o), .wr_res_ready_i(wr_res_ready_i),
        .rd_req_addr_i(rd_req_addr_i), .rd_req_valid_i(rd_req_valid_i), .rd_req_ready_o(rd_req_ready_o),
        .rd_res_o(rd_res_o), .rd_res_valid_o(rd_res_valid_o), .rd_res_ready_i(rd_res_ready_i),
        .lkp_req_addr_o(lkp_req_addr_o), .lkp_req_valid_o(lkp_req_valid_o), .lkp_req_ready_i(lkp_req_ready_i),
        .lkp_res_i(lkp_res_i), .lkp_res_valid_i(lkp_res_valid_i), .lkp_res_ready_o(lkp_res_ready_o),
        .outstanding_o(outstanding_o)
    );

    function automatic logic [15:0] res_of(input logic [31:0] a);
        return a[15:0] ^ 16'hA5A5;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sb_pop(output exp_t x, output bit got);
        got = (exp_q.size() != 0);
        x   = got ? exp_q.pop_front() : '1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        wr_req_valid_i = 0; rd_req_valid_i = 0; lkp_req_ready_i = 1; lkp_res_valid_i = 0;
        wr_res_ready_i = 1; rd_res_ready_i = 1;
        wr_req_addr_i = '0; rd_req_addr_i = '0; lkp_res_i = '0;
        @(negedge clk_i);
        tests_run++;
        if ({lkp_req_valid_o, wr_req_ready_o, rd_req_ready_o, lkp_res_ready_o, wr_res_valid_o, rd_res_valid_o} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b required 000000", {lkp_req_valid_o, wr_req_ready_o, rd_req_ready_o, lkp_res_ready_o, wr_res_valid_o, rd_res_valid_o});
        end
        tests_run++;
        if (outstanding_o !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_outstanding: got %0d required 0", outstanding_o);
        end
        tick();
        rst_ni = 1'b1;
        $display("[TB] reset done");
    endtask

    task automatic test_single_wr();
        tick();
        wr_req_valid_i = 1; wr_req_addr_i = 32'h1000;
        @(negedge clk_i);
        tests_run++;
        if ({lkp_req_valid_o, wr_req_ready_o, rd_req_ready_o} !== 3'b110 || lkp_req_addr_o !== 32'h1000) begin
            tests_failed++;
            $display("FAIL single_req: v/wr/rd=%b addr=%h required 110 addr=00001000", {lkp_req_valid_o, wr_req_ready_o, rd_req_ready_o}, lkp_req_addr_o);
        end
        exp_q.push_back({1'b0, res_of(32'h1000)});
        tick();
        wr_req_valid_i = 0; lkp_res_valid_i = 1; lkp_res_i = res_of(32'h1000);
        @(negedge clk_i);
        tests_run++;
        if (outstanding_o !== 2'd1 || lkp_res_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_outstanding1: got %0d ready=%b required 1 ready=1", outstanding_o, lkp_res_ready_o);
        end
        sb_pop(e, ok); tests_run++;
        if (!ok || {wr_res_valid_o, rd_res_valid_o} !== {!e.rd, e.rd} || (e.rd ? rd_res_o : wr_res_o) !== e.data) begin
            tests_failed++;
            $display("FAIL single_res: wr_v=%b rd_v=%b wr=%h rd=%h required side=%0d data=%h", wr_res_valid_o, rd_res_valid_o, wr_res_o, rd_res_o, e.rd, e.data);
        end
        tick();
        lkp_res_valid_i = 0;
        @(negedge clk_i);
        tests_run++;
        if (outstanding_o !== 2'd0) begin
            tests_failed++;
            $display("FAIL single_outstanding0: got %0d required 0", outstanding_o);
        end
        $display("[TB] single write lookup done");
    endtask

    task automatic test_lock_stall();
        // Pointer favours rd here (last handshake was wr), so only the lock keeps wr granted.
        tick();
        wr_req_valid_i = 1; wr_req_addr_i = 32'h1000; lkp_req_ready_i = 0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) begin
                tick();
                rd_req_valid_i = 1; rd_req_addr_i = 32'h2000;
            end
            @(negedge clk_i);
            tests_run++;
            if ({lkp_req_valid_o, wr_req_ready_o, rd_req_ready_o} !== 3'b100 || lkp_req_addr_o !== 32'h1000) begin
                tests_failed++;
                $display("FAIL lock_hold c%0d: v/wr/rd=%b addr=%h required 100 addr=00001000", c, {lkp_req_valid_o, wr_req_ready_o, rd_req_ready_o}, lkp_req_addr_o);
            end
        end
        tick();
        lkp_req_ready_i = 1;
        @(negedge clk_i);
        tests_run++;
        if ({wr_req_ready_o, rd_req_ready_o} !== 2'b10 || lkp_req_addr_o !== 32'h1000) begin
            tests_failed++;
            $display("FAIL lock_release: wr/rd=%b addr=%h required 10 addr=00001000", {wr_req_ready_o, rd_req_ready_o}, lkp_req_addr_o);
        end
        exp_q.push_back({1'b0, res_of(32'h1000)});
        tick();
        wr_req_valid_i = 0; lkp_res_valid_i = 1; lkp_res_i = res_of(32'h1000);
        @(negedge clk_i);
        tests_run++;
        if ({wr_req_ready_o, rd_req_ready_o} !== 2'b01 || lkp_req_addr_o !== 32'h2000) begin
            tests_failed++;
            $display("FAIL lock_rd_next: wr/rd=%b addr=%h required 01 addr=00002000", {wr_req_ready_o, rd_req_ready_o}, lkp_req_addr_o);
        end
        sb_pop(e, ok); tests_run++;
        if (!ok || {wr_res_valid_o, rd_res_valid_o} !== {!e.rd, e.rd} || (e.rd ? rd_res_o : wr_res_o) !== e.data) begin
            tests_failed++;
            $display("FAIL lock_res_wr: wr_v=%b rd_v=%b wr=%h rd=%h required side=%0d data=%h", wr_res_valid_o, rd_res_valid_o, wr_res_o, rd_res_o, e.rd, e.data);
        end
        exp_q.push_back({1'b1, res_of(32'h2000)});
        tick();
        rd_req_valid_i = 0; lkp_res_i = res_of(32'h2000);
        @(negedge clk_i);
        sb_pop(e, ok); tests_run++;
        if (!ok || {wr_res_valid_o, rd_res_valid_o} !== {!e.rd, e.rd} || (e.rd ? rd_res_o : wr_res_o) !== e.data) begin
            tests_failed++;
            $display("FAIL lock_res_rd: wr_v=%b rd_v=%b wr=%h rd=%h required side=%0d data=%h", wr_res_valid_o, rd_res_valid_o, wr_res_o, rd_res_o, e.rd, e.data);
        end
        tick();
        lkp_res_valid_i = 0;
        $display("[TB] lock stall done");
    endtask

    task automatic test_alternate();
        logic [31:0] exp_addr, prev_addr;
        prev_addr = '0;
        tick(); rst_ni = 0;
        tick(); rst_ni = 1;
        for (int k = 0; k < 4; k++) begin
            tick();
            wr_req_valid_i = (k <= 2); wr_req_addr_i = 32'h1000;
            rd_req_valid_i = 1;        rd_req_addr_i = 32'h2000;
            lkp_res_valid_i = (k >= 1); lkp_res_i = res_of(prev_addr);
            exp_addr = (k % 2 == 1) ? 32'h2000 : 32'h1000;
            @(negedge clk_i);
            tests_run++;
            if (lkp_req_addr_o !== exp_addr || {wr_req_ready_o, rd_req_ready_o} !== ((k % 2 == 1) ? 2'b01 : 2'b10)) begin
                tests_failed++;
                $display("FAIL alt_grant k%0d: addr=%h wr/rd=%b required addr=%h", k, lkp_req_addr_o, {wr_req_ready_o, rd_req_ready_o}, exp_addr);
            end
            if (k >= 1) begin
                sb_pop(e, ok); tests_run++;
                if (!ok || {wr_res_valid_o, rd_res_valid_o} !== {!e.rd, e.rd} || (e.rd ? rd_res_o : wr_res_o) !== e.data) begin
                    tests_failed++;
                    $display("FAIL alt_res k%0d: wr_v=%b rd_v=%b wr=%h rd=%h required side=%0d data=%h", k, wr_res_valid_o, rd_res_valid_o, wr_res_o, rd_res_o, e.rd, e.data);
                end
            end
            exp_q.push_back({(k % 2 == 1), res_of(exp_addr)});
            prev_addr = exp_addr;
        end
        tick();
        wr_req_valid_i = 0; rd_req_valid_i = 0; lkp_res_valid_i = 1; lkp_res_i = res_of(prev_addr);
        @(negedge clk_i);
        sb_pop(e, ok); tests_run++;
        if (!ok || {wr_res_valid_o, rd_res_valid_o} !== {!e.rd, e.rd} || (e.rd ? rd_res_o : wr_res_o) !== e.data) begin
            tests_failed++;
            $display("FAIL alt_res_last: wr_v=%b rd_v=%b wr=%h rd=%h required side=%0d data=%h", wr_res_valid_o, rd_res_valid_o, wr_res_o, rd_res_o, e.rd, e.data);
        end
        tick();
        lkp_res_valid_i = 0;
        $display("[TB] alternating grants done");
    endtask

    task automatic test_full();
        logic [31:0] addrs [3];
        addrs[0] = 32'h3000; addrs[1] = 32'h3004; addrs[2] = 32'h3008;
        for (int k = 0; k < 3; k++) begin
            tick();
            wr_req_valid_i = 1; wr_req_addr_i = addrs[k];
            @(negedge clk_i);
            tests_run++;
            if (outstanding_o !== 2'(k) || {lkp_req_valid_o, wr_req_ready_o} !== ((k < 2) ? 2'b11 : 2'b00)) begin
                tests_failed++;
                $display("FAIL full_fill k%0d: outstanding=%0d v/wr=%b required %0d", k, outstanding_o, {lkp_req_valid_o, wr_req_ready_o}, k);
            end
            if (k < 2) exp_q.push_back({1'b0, res_of(addrs[k])});
        end
        tick();
        lkp_res_valid_i = 1; lkp_res_i = res_of(addrs[0]);
        @(negedge clk_i);
        tests_run++;
        if (outstanding_o !== 2'd2 || {lkp_req_valid_o, wr_req_ready_o} !== 2'b00) begin
            tests_failed++;
            $display("FAIL full_pop_blocks_push: outstanding=%0d v/wr=%b required 2 00", outstanding_o, {lkp_req_valid_o, wr_req_ready_o});
        end
        sb_pop(e, ok); tests_run++;
        if (!ok || {wr_res_valid_o, rd_res_valid_o} !== {!e.rd, e.rd} || (e.rd ? rd_res_o : wr_res_o) !== e.data) begin
            tests_failed++;
            $display("FAIL full_res0: wr_v=%b rd_v=%b wr=%h required side=%0d data=%h", wr_res_valid_o, rd_res_valid_o, wr_res_o, e.rd, e.data);
        end
        tick();
        lkp_res_valid_i = 0;
        @(negedge clk_i);
        tests_run++;
        if (outstanding_o !== 2'd1 || {lkp_req_valid_o, wr_req_ready_o} !== 2'b11) begin
            tests_failed++;
            $display("FAIL full_push_after: outstanding=%0d v/wr=%b required 1 11", outstanding_o, {lkp_req_valid_o, wr_req_ready_o});
        end
        exp_q.push_back({1'b0, res_of(addrs[2])});
        for (int k = 1; k < 3; k++) begin
            tick();
            wr_req_valid_i = 0; lkp_res_valid_i = 1; lkp_res_i = res_of(addrs[k]);
            @(negedge clk_i);
            sb_pop(e, ok); tests_run++;
            if (!ok || outstanding_o !== 2'(3 - k) || {wr_res_valid_o, rd_res_valid_o} !== {!e.rd, e.rd} || wr_res_o !== e.data) begin
                tests_failed++;
                $display("FAIL full_drain k%0d: outstanding=%0d wr_v=%b wr=%h required %0d data=%h", k, outstanding_o, wr_res_valid_o, wr_res_o, 3 - k, e.data);
            end
        end
        tick();
        lkp_res_valid_i = 0;
        @(negedge clk_i);
        tests_run++;
        if (outstanding_o !== 2'd0) begin
            tests_failed++;
            $display("FAIL full_empty: outstanding=%0d required 0", outstanding_o);
        end
        $display("[TB] full / pop-push done");
    endtask

    task automatic test_hol();
        tick();
        wr_req_valid_i = 1; wr_req_addr_i = 32'h4000;
        exp_q.push_back({1'b0, res_of(32'h4000)});
        tick();
        wr_req_valid_i = 0; rd_req_valid_i = 1; rd_req_addr_i = 32'h5000;
        @(negedge clk_i);
        tests_run++;
        if (rd_req_ready_o !== 1'b1 || lkp_req_addr_o !== 32'h5000) begin
            tests_failed++;
            $display("FAIL hol_rd_req: rd_ready=%b addr=%h required 1 00005000", rd_req_ready_o, lkp_req_addr_o);
        end
        exp_q.push_back({1'b1, res_of(32'h5000)});
        tick();
        rd_req_valid_i = 0; lkp_res_valid_i = 1; lkp_res_i = res_of(32'h4000); wr_res_ready_i = 0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) tick();
            @(negedge clk_i);
            tests_run++;
            if ({wr_res_valid_o, rd_res_valid_o, lkp_res_ready_o} !== 3'b100) begin
                tests_failed++;
                $display("FAIL hol_block c%0d: wr_v/rd_v/ready=%b required 100", c, {wr_res_valid_o, rd_res_valid_o, lkp_res_ready_o});
            end
        end
        tick();
        wr_res_ready_i = 1;
        for (int k = 0; k < 2; k++) begin
            if (k == 1) begin
                tick();
                lkp_res_i = res_of(32'h5000);
            end
            @(negedge clk_i);
            sb_pop(e, ok); tests_run++;
            if (!ok || lkp_res_ready_o !== 1'b1 || {wr_res_valid_o, rd_res_valid_o} !== {!e.rd, e.rd} || (e.rd ? rd_res_o : wr_res_o) !== e.data) begin
                tests_failed++;
                $display("FAIL hol_release k%0d: wr_v=%b rd_v=%b wr=%h rd=%h required side=%0d data=%h", k, wr_res_valid_o, rd_res_valid_o, wr_res_o, rd_res_o, e.rd, e.data);
            end
        end
        tick();
        lkp_res_valid_i = 0;
        $display("[TB] head-of-line blocking done");
    endtask

    task automatic test_async_reset();
        tick();
        rd_req_valid_i = 1; rd_req_addr_i = 32'h7000;
        tick();
        rd_req_valid_i = 0; wr_req_valid_i = 1; wr_req_addr_i = 32'h6000;
        tick();
        wr_req_valid_i = 0;
        @(negedge clk_i);
        tests_run++;
        if (outstanding_o !== 2'd2) begin
            tests_failed++;
            $display("FAIL arst_pre: outstanding=%0d required 2", outstanding_o);
        end
        #1 rst_ni = 0;
        #1;
        tests_run++;
        if (outstanding_o !== 2'd0 || {lkp_req_valid_o, wr_req_ready_o, rd_req_ready_o, lkp_res_ready_o, wr_res_valid_o, rd_res_valid_o} !== 6'b0) begin
            tests_failed++;
            $display("FAIL arst_immediate: outstanding=%0d ctrl=%b required 0 000000", outstanding_o, {lkp_req_valid_o, wr_req_ready_o, rd_req_ready_o, lkp_res_ready_o, wr_res_valid_o, rd_res_valid_o});
        end
        exp_q.delete();
        tick();
        rst_ni = 1;
        wr_req_valid_i = 1; wr_req_addr_i = 32'h8000; rd_req_valid_i = 1; rd_req_addr_i = 32'h9000;
        @(negedge clk_i);
        tests_run++;
        if (lkp_req_addr_o !== 32'h8000 || {wr_req_ready_o, rd_req_ready_o} !== 2'b10) begin
            tests_failed++;
            $display("FAIL arst_first_grant: addr=%h wr/rd=%b required 00008000 10", lkp_req_addr_o, {wr_req_ready_o, rd_req_ready_o});
        end
        exp_q.push_back({1'b0, res_of(32'h8000)});
        tick();
        wr_req_valid_i = 0; lkp_res_valid_i = 1; lkp_res_i = res_of(32'h8000);
        @(negedge clk_i);
        sb_pop(e, ok); tests_run++;
        if (!ok || {wr_res_valid_o, rd_res_valid_o} !== {!e.rd, e.rd} || wr_res_o !== e.data || rd_req_ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL arst_res_wr: wr_v=%b rd_v=%b wr=%h rd_ready=%b required data=%h", wr_res_valid_o, rd_res_valid_o, wr_res_o, rd_req_ready_o, e.data);
        end
        exp_q.push_back({1'b1, res_of(32'h9000)});
        tick();
        rd_req_valid_i = 0; lkp_res_i = res_of(32'h9000);
        @(negedge clk_i);
        sb_pop(e, ok); tests_run++;
        if (!ok || {wr_res_valid_o, rd_res_valid_o} !== {!e.rd, e.rd} || rd_res_o !== e.data) begin
            tests_failed++;
            $display("FAIL arst_res_rd: wr_v=%b rd_v=%b rd=%h required data=%h", wr_res_valid_o, rd_res_valid_o, rd_res_o, e.data);
        end
        tick();
        lkp_res_valid_i = 0;
        @(negedge clk_i);
        tests_run++;
        if (outstanding_o !== 2'd0) begin
            tests_failed++;
            $display("FAIL arst_drained: outstanding=%0d required 0", outstanding_o);
        end
        $display("[TB] async reset done");
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within 200000 time units");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_wr();
        test_lock_stall();
        test_alternate();
        test_full();
        test_hol();
        test_async_reset();
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_left: %0d entries remaining, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
